// File: rtl/cell_framebuffer.sv
// Double-buffered 40x30 one-bit cell framebuffer feeding the VGA output stage.
// Writes and row clears target the hidden back bank; banks swap on a vsync falling edge.
module cell_framebuffer #(
   parameter int COLS  = 40,
   parameter int ROWS  = 30,
   parameter int CELLS = COLS * ROWS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [5:0]       wr_x,
   input  logic [4:0]       wr_y,
   input  logic             wr_data,
   output logic             wr_oob,
   input  logic             clear_req,
   output logic             clear_busy,
   input  logic             swap_req,
   output logic             swap_pending,
   input  logic             v_sync_in,
   output logic             frame_swapped,
   output logic             front_sel,
   output logic [CELLS-1:0] display_data
);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t           state_q, state_d;
   logic [4:0]       row_q, row_d;
   logic [CELLS-1:0] bank_a_q, bank_b_q, display_q;
   logic             front_sel_q, front_sel_d;
   logic             swap_pending_q, swap_pending_d;
   logic             vs_q, wr_oob_q, frame_swapped_q;

   logic             wr_accept, wr_in_range, vs_fall, swap_exec, back_is_a;
   logic [10:0]      wr_idx, clr_base;

   assign wr_ready    = (state_q == ST_IDLE) && !swap_pending_q && !clear_req;
   assign wr_accept   = wr_valid && wr_ready;
   assign wr_in_range = (wr_x < 6'(COLS)) && (wr_y < 5'(ROWS));
   // Index only formed for legal coordinates so an OOB write can never alias a real cell.
   assign wr_idx      = wr_in_range ? (11'(wr_y) * 11'(COLS) + 11'(wr_x)) : 11'd0;
   assign clr_base    = 11'(row_q) * 11'(COLS);
   assign back_is_a   = front_sel_q;

   assign vs_fall     = vs_q & ~v_sync_in;
   assign swap_exec   = vs_fall && (state_q == ST_IDLE) && (swap_pending_q || swap_req);

   always_comb begin
      state_d        = state_q;
      row_d          = row_q;
      front_sel_d    = front_sel_q;
      swap_pending_d = swap_pending_q | swap_req;
      case (state_q)
         ST_IDLE: begin
            if (clear_req && !swap_pending_q) begin
               state_d = ST_CLEAR;
               row_d   = 5'd0;
            end
         end
         ST_CLEAR: begin
            if (row_q == 5'(ROWS - 1)) begin
               state_d = ST_IDLE;
               row_d   = 5'd0;
            end else begin
               row_d = row_q + 5'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (swap_exec) begin
         front_sel_d    = ~front_sel_q;
         swap_pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         row_q           <= 5'd0;
         front_sel_q     <= 1'b0;
         swap_pending_q  <= 1'b0;
         vs_q            <= 1'b1;
         wr_oob_q        <= 1'b0;
         frame_swapped_q <= 1'b0;
         display_q       <= '0;
      end else begin
         state_q         <= state_d;
         row_q           <= row_d;
         front_sel_q     <= front_sel_d;
         swap_pending_q  <= swap_pending_d;
         vs_q            <= v_sync_in;
         wr_oob_q        <= wr_accept && !wr_in_range;
         frame_swapped_q <= swap_exec;
         display_q       <= front_sel_q ? bank_b_q : bank_a_q;
      end
   end

   // Clear and write never coincide: wr_ready is low for the whole clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         bank_a_q <= '0;
         bank_b_q <= '0;
      end else begin
         if (state_q == ST_CLEAR) begin
            if (back_is_a) bank_a_q[clr_base +: COLS] <= '0;
            else           bank_b_q[clr_base +: COLS] <= '0;
         end
         if (wr_accept && wr_in_range) begin
            if (back_is_a) bank_a_q[wr_idx] <= wr_data;
            else           bank_b_q[wr_idx] <= wr_data;
         end
      end
   end

   assign clear_busy    = (state_q == ST_CLEAR);
   assign swap_pending  = swap_pending_q;
   assign frame_swapped = frame_swapped_q;
   assign front_sel     = front_sel_q;
   assign wr_oob        = wr_oob_q;
   assign display_data  = display_q;

endmodule

// File: tb/tb_cell_framebuffer.sv
// Self-checking bench for cell_framebuffer: write table, clear/swap/reset
// sequences, then randomized traffic against a bank-array reference model.
module tb_cell_framebuffer;

   localparam int COLS  = 40;
   localparam int ROWS  = 30;
   localparam int CELLS = 1200;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             wr_valid = 1'b0, wr_data = 1'b0;
   logic [5:0]       wr_x = '0;
   logic [4:0]       wr_y = '0;
   logic             clear_req = 1'b0, swap_req = 1'b0, v_sync_in = 1'b1;
   logic             wr_ready, wr_oob, clear_busy, swap_pending, frame_swapped, front_sel;
   logic [CELLS-1:0] display_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #10 clk = ~clk;

   cell_framebuffer dut (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .wr_oob(wr_oob),
      .clear_req(clear_req), .clear_busy(clear_busy),
      .swap_req(swap_req), .swap_pending(swap_pending),
      .v_sync_in(v_sync_in), .frame_swapped(frame_swapped),
      .front_sel(front_sel), .display_data(display_data)
   );

   // Reference model: two bank arrays, a front index and a remaining-rows count.
   logic [CELLS-1:0] m_bank [2];
   int               m_front, m_clr_left, m_clr_row;
   bit               m_pend, m_vs, m_oob, m_fsw;
   logic [CELLS-1:0] m_disp;

   task automatic model_reset();
      m_bank[0] = '0; m_bank[1] = '0;
      m_front = 0; m_clr_left = 0; m_clr_row = 0;
      m_pend = 0; m_vs = 1; m_oob = 0; m_fsw = 0; m_disp = '0;
   endtask

   function automatic bit m_ready();
      return (m_clr_left == 0) && !m_pend && !clear_req;
   endfunction

   task automatic model_edge();
      bit fall, idle, acc, swp, inr;
      int back;
      if (reset) begin
         model_reset();
         return;
      end
      fall = m_vs && !v_sync_in;
      idle = (m_clr_left == 0);
      acc  = wr_valid && m_ready();
      swp  = fall && idle && (m_pend || swap_req);
      back = 1 - m_front;
      m_disp = m_bank[m_front];
      if (!idle) begin
         for (int c = 0; c < COLS; c++) m_bank[back][m_clr_row*COLS + c] = 1'b0;
         m_clr_row++;
         m_clr_left--;
      end else if (clear_req && !m_pend) begin
         m_clr_left = ROWS;
         m_clr_row  = 0;
      end
      inr = (int'(wr_x) < COLS) && (int'(wr_y) < ROWS);
      if (acc && inr) m_bank[back][int'(wr_y)*COLS + int'(wr_x)] = wr_data;
      m_oob = acc && !inr;
      m_fsw = swp;
      if (swp) begin
         m_front = 1 - m_front;
         m_pend  = 0;
      end else if (swap_req) begin
         m_pend = 1;
      end
      m_vs = v_sync_in;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_disp(string name, logic [CELLS-1:0] exp);
      n_cmp++;
      if (display_data !== exp) begin
         n_bad++;
         for (int i = 0; i < CELLS; i++)
            if (display_data[i] !== exp[i]) begin
               $display("FAIL %s: display_data[%0d] got %b expected %b at %0t",
                        name, i, display_data[i], exp[i], $time);
               break;
            end
      end
   endtask

   // One clock: check combinational ready, clock, update model, check registered outputs.
   task automatic cyc();
      #1;
      if (!reset) chk("wr_ready", 32'(wr_ready), 32'(m_ready()));
      @(posedge clk);
      model_edge();
      #1;
      chk("front_sel", 32'(front_sel), 32'(m_front));
      chk("swap_pending", 32'(swap_pending), 32'(m_pend));
      chk("clear_busy", 32'(clear_busy), 32'(m_clr_left != 0));
      chk("wr_oob", 32'(wr_oob), 32'(m_oob));
      chk("frame_swapped", 32'(frame_swapped), 32'(m_fsw));
      chk_disp("display_data", m_disp);
   endtask

   typedef struct {
      int x; int y; bit d; bit exp_oob; int exp_idx;
   } wvec_t;

   wvec_t tbl [8];

   initial begin
      int busy_cnt, fsw_cnt, vcnt;

      tbl[0] = '{5, 2, 1'b1, 1'b0, 85};
      tbl[1] = '{39, 29, 1'b1, 1'b0, 1199};
      tbl[2] = '{0, 0, 1'b1, 1'b0, 0};
      tbl[3] = '{40, 0, 1'b1, 1'b1, 0};
      tbl[4] = '{0, 30, 1'b1, 1'b1, 0};
      tbl[5] = '{63, 31, 1'b1, 1'b1, 0};
      tbl[6] = '{1, 1, 1'b1, 1'b0, 41};
      tbl[7] = '{20, 15, 1'b1, 1'b0, 620};

      model_reset();
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      chk("rst_front_sel", 32'(front_sel), 32'd0);
      chk("rst_pending", 32'(swap_pending), 32'd0);
      chk("rst_busy", 32'(clear_busy), 32'd0);
      chk("rst_display_ones", 32'($countones(display_data)), 32'd0);

      // Write table into back bank B, then swap it to the front.
      foreach (tbl[i]) begin
         wr_valid = 1'b1; wr_x = 6'(tbl[i].x); wr_y = 5'(tbl[i].y); wr_data = tbl[i].d;
         cyc();
         chk("tbl_oob", 32'(wr_oob), 32'(tbl[i].exp_oob));
      end
      wr_valid = 1'b0;
      cyc();
      chk("tbl_oob_one_cycle", 32'(wr_oob), 32'd0);
      chk("pre_swap_disp85", 32'(display_data[85]), 32'd0);
      swap_req = 1'b1; cyc(); swap_req = 1'b0;
      v_sync_in = 1'b0; cyc();
      chk("swap_pulse", 32'(frame_swapped), 32'd1);
      chk("swap_front", 32'(front_sel), 32'd1);
      chk("swap_disp_latency", 32'(display_data[85]), 32'd0);
      v_sync_in = 1'b1; cyc();
      chk("swap_pulse_one_cycle", 32'(frame_swapped), 32'd0);
      foreach (tbl[i])
         if (!tbl[i].exp_oob) chk("tbl_disp_bit", 32'(display_data[tbl[i].exp_idx]), 32'(tbl[i].d));
      chk("tbl_disp_ones", 32'($countones(display_data)), 32'd5);

      // Fill back bank A with ones, then clear it with a swap requested mid-clear.
      for (int y = 0; y < ROWS; y++)
         for (int x = 0; x < COLS; x++) begin
            wr_valid = 1'b1; wr_x = 6'(x); wr_y = 5'(y); wr_data = 1'b1;
            cyc();
         end
      wr_x = 6'd3; wr_y = 5'd3; wr_data = 1'b0; clear_req = 1'b1;
      #1 chk("clear_beats_write", 32'(wr_ready), 32'd0);
      cyc();
      clear_req = 1'b0; wr_valid = 1'b0;
      busy_cnt = int'(clear_busy);
      fsw_cnt = 0;
      for (int k = 0; k < 34; k++) begin
         swap_req  = (k == 3);
         v_sync_in = (k == 8) ? 1'b0 : 1'b1;
         cyc();
         if (clear_busy) begin
            busy_cnt++;
            chk("ready_low_in_clear", 32'(wr_ready), 32'd0);
         end
         fsw_cnt += int'(frame_swapped);
      end
      swap_req = 1'b0;
      chk("clear_len", 32'(busy_cnt), 32'd30);
      chk("no_swap_in_clear", 32'(fsw_cnt), 32'd0);
      chk("pending_kept", 32'(swap_pending), 32'd1);
      chk("front_kept", 32'(front_sel), 32'd1);
      v_sync_in = 1'b0; cyc();
      chk("deferred_swap", 32'(frame_swapped), 32'd1);
      chk("deferred_front", 32'(front_sel), 32'd0);
      v_sync_in = 1'b1; cyc();
      chk("cleared_bank_ones", 32'($countones(display_data)), 32'd0);

      // Pending swap blocks writes; a second request does not double-toggle.
      swap_req = 1'b1; cyc(); swap_req = 1'b0;
      wr_valid = 1'b1; wr_x = 6'd7; wr_y = 5'd7; wr_data = 1'b1;
      for (int k = 0; k < 4; k++) begin
         swap_req = (k == 2);
         cyc();
         chk("ready_low_pending", 32'(wr_ready), 32'd0);
      end
      swap_req = 1'b0;
      v_sync_in = 1'b0; cyc();
      chk("swap2_pulse", 32'(frame_swapped), 32'd1);
      chk("swap2_front", 32'(front_sel), 32'd1);
      chk("ready_after_swap", 32'(wr_ready), 32'd1);
      v_sync_in = 1'b1; cyc();
      wr_valid = 1'b0;
      for (int k = 0; k < 5; k++) cyc();
      chk("single_toggle", 32'(front_sel), 32'd1);

      // Reset on clear cycle 12 with a swap pending.
      clear_req = 1'b1; cyc(); clear_req = 1'b0;
      swap_req = 1'b1; cyc(); swap_req = 1'b0;
      for (int k = 0; k < 10; k++) cyc();
      chk("mid_clear_busy", 32'(clear_busy), 32'd1);
      reset = 1'b1; cyc(); reset = 1'b0;
      chk("abort_busy", 32'(clear_busy), 32'd0);
      chk("abort_pending", 32'(swap_pending), 32'd0);
      chk("abort_front", 32'(front_sel), 32'd0);
      chk("abort_display", 32'($countones(display_data)), 32'd0);

      // Randomized traffic against the model.
      vcnt = 0;
      for (int n = 0; n < 3000; n++) begin
         wr_valid  = ($urandom_range(0, 9) < 7);
         wr_x      = 6'($urandom_range(0, 42));
         wr_y      = 5'($urandom_range(0, 31));
         wr_data   = 1'($urandom);
         clear_req = ($urandom_range(0, 99) < 3);
         swap_req  = ($urandom_range(0, 99) < 5);
         reset     = ($urandom_range(0, 999) < 2);
         v_sync_in = (vcnt < 3) ? 1'b0 : 1'b1;
         vcnt      = (vcnt + 1) % 47;
         cyc();
      end
      reset = 1'b0; wr_valid = 1'b0; clear_req = 1'b0; swap_req = 1'b0; v_sync_in = 1'b1;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
